// File: rtl/temp_readout_proc.sv
// Temperature readout processor: averages raw two's-complement samples, tracks min/max,
// converts to tenths of C/F/K and produces BCD digits with leading-zero blanking.
module temp_readout_proc #(
  parameter int W        = 13,
  parameter int FRAC     = 4,
  parameter int AVG_LOG2 = 0,
  parameter int NDIG     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      temp,
  input  logic              temp_valid,
  input  logic [1:0]        unit,
  input  logic [1:0]        sel,
  input  logic              clr_minmax,
  output logic [4*NDIG-1:0] digits,
  output logic              neg,
  output logic [NDIG-1:0]   blank,
  output logic              ovf,
  output logic              out_valid,
  output logic              busy
);

  localparam int MAGW = W + 6;
  localparam int TW   = MAGW + 1;
  localparam int SW   = W + AVG_LOG2;
  localparam int CW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DW   = 4 * NDIG;
  localparam int BW   = $clog2(MAGW);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]          LIMIT     = pow10(NDIG);
  localparam logic [NDIG-1:0]      BLANK_RST = ~NDIG'(3);
  localparam logic signed [TW-1:0] K10       = TW'(10);
  localparam logic signed [TW-1:0] K18       = TW'(18);
  localparam logic signed [TW-1:0] OFS_F     = TW'(320);
  localparam logic signed [TW-1:0] OFS_K     = TW'(2732);

  typedef enum logic [1:0] {IDLE, CALC, BCD, DONE} state_t;
  state_t state, state_next;

  logic signed [SW-1:0] acc, sum_next;
  logic [CW-1:0]        cnt;
  logic                 last_sample, avg_strobe, req;
  logic signed [W-1:0]  avg_next, avg_q, min_q, max_q;
  logic                 have_avg, mm_valid, pending;
  logic [1:0]           unit_q, sel_q;

  logic signed [W-1:0]  src;
  logic signed [TW-1:0] src_ext, t_val;
  logic [MAGW-1:0]      mag;
  logic                 ovf_calc;

  logic [DW-1:0]        bcd_q;
  logic [MAGW-1:0]      bin_q;
  logic [BW-1:0]        bit_cnt;
  logic                 neg_q, ovf_q;
  logic [DW+MAGW-1:0]   dd_shift;
  logic [NDIG-1:0]      blank_calc;
  logic                 lead;

  assign sum_next    = acc + SW'(signed'(temp));
  assign avg_next    = W'(sum_next >>> AVG_LOG2);
  assign last_sample = (cnt == CW'((1 << AVG_LOG2) - 1));
  assign avg_strobe  = temp_valid & last_sample;
  assign req         = avg_strobe | (have_avg & ((unit != unit_q) | (sel != sel_q)));
  assign busy        = (state != IDLE);

  // Sample intake runs regardless of FSM state so no sample is lost while converting.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block and
    // every state register uses non-blocking assignment to avoid ordering races.
    if (!rst) begin
      acc      <= '0;
      cnt      <= '0;
      avg_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      have_avg <= 1'b0;
      mm_valid <= 1'b0;
      pending  <= 1'b0;
      unit_q   <= 2'd0;
      sel_q    <= 2'd0;
    end else begin
      unit_q  <= unit;
      sel_q   <= sel;
      pending <= req | (pending & (state != IDLE));
      if (temp_valid) begin
        if (last_sample) begin
          acc      <= '0;
          cnt      <= '0;
          avg_q    <= avg_next;
          have_avg <= 1'b1;
        end else begin
          acc <= sum_next;
          cnt <= cnt + 1'b1;
        end
      end
      if (avg_strobe) begin
        mm_valid <= 1'b1;
        if (clr_minmax || !mm_valid) begin
          min_q <= avg_next;
          max_q <= avg_next;
        end else begin
          if (avg_next < min_q) min_q <= avg_next;
          if (avg_next > max_q) max_q <= avg_next;
        end
      end else if (clr_minmax) begin
        mm_valid <= 1'b0;
      end
    end
  end

  // Unit conversion into signed tenths, evaluated during CALC.
  always_comb begin
    // NOTE: every variable gets a value on every path, so no latch is inferred.
    case (sel_q)
      2'd1:    src = min_q;
      2'd2:    src = max_q;
      default: src = avg_q;
    endcase
    src_ext = TW'(src);
    case (unit_q)
      2'd1:    t_val = ((src_ext * K18) >>> FRAC) + OFS_F;
      2'd2:    t_val = ((src_ext * K10) >>> FRAC) + OFS_K;
      default: t_val = (src_ext * K10) >>> FRAC;
    endcase
    mag      = MAGW'(t_val[TW-1] ? -t_val : t_val);
    ovf_calc = (64'(mag) >= LIMIT);
  end

  function automatic logic [DW-1:0] add3(input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = b;
    for (int i = 0; i < NDIG; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  assign dd_shift = {add3(bcd_q), bin_q} << 1;

  // Leading zeros blank from the top down; tenths and units always stay visible.
  always_comb begin
    blank_calc = '0;
    lead       = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (i >= 2 && lead && bcd_q[4*i +: 4] == 4'd0) blank_calc[i] = 1'b1;
      else                                           lead          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pending) state_next = CALC;
      CALC: state_next = BCD;
      BCD:  if (bit_cnt == BW'(MAGW - 1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bcd_q     <= '0;
      bin_q     <= '0;
      bit_cnt   <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      digits    <= '0;
      neg       <= 1'b0;
      blank     <= BLANK_RST;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        CALC: begin
          bin_q   <= mag;
          bcd_q   <= '0;
          bit_cnt <= '0;
          neg_q   <= t_val[TW-1];
          ovf_q   <= ovf_calc;
        end
        BCD: begin
          bcd_q   <= dd_shift[DW+MAGW-1:MAGW];
          bin_q   <= dd_shift[MAGW-1:0];
          bit_cnt <= bit_cnt + 1'b1;
        end
        DONE: begin
          digits    <= ovf_q ? {NDIG{4'h9}} : bcd_q;
          blank     <= ovf_q ? '0 : blank_calc;
          neg       <= neg_q;
          ovf       <= ovf_q;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
